// File: rtl/memory2.sv
// memory2: second memory pipeline stage, between Memory1 and writeback.
// Takes the dcache load response, aligns and extends the load data, picks
// the rd write data, forwards it to decode/execute and hands the instruction
// and its exception state to writeback. A load stays in the stage until its
// data arrives. One early response can be buffered. The response of a
// flushed load is swallowed.

package memory2_pkg;
  typedef logic [31:0] u32_t;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef struct packed {
    logic       valid;
    logic       data_valid;
    logic [4:0] idx;
    u32_t       data;
  } forward_req_t;

  typedef struct packed {
    logic       valid;
    logic       is_mem;
    logic       is_store;
    logic       is_signed;
    logic [1:0] mem_size;
    logic [1:0] byte_en;
    logic       is_wr_rd;
    logic       is_wr_rd_pc_plus4;
    logic [4:0] rd;
    u32_t       pc_plus4;
    u32_t       ex_out;
  } memory1_memory2_pass_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] cause;
    u32_t       tval;
  } excp_pass_t;

  typedef struct packed {
    logic       valid;
    logic       is_wr_rd;
    logic [4:0] rd;
    u32_t       wr_data;
  } memory2_writeback_pass_t;
endpackage

module memory2
  import memory2_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dcache_data_valid,
  input  logic [31:0]             dcache_rdata,
  output forward_req_t            fwd_req,
  input  logic                    flush,
  input  logic                    next_rdy_in,
  output logic                    rdy_in,
  input  memory1_memory2_pass_t   pass_in,
  input  excp_pass_t              excp_pass_in,
  output memory2_writeback_pass_t pass_out,
  output excp_pass_t              excp_pass_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  memory1_memory2_pass_t pass_in_q;
  excp_pass_t            excp_pass_in_q;
  logic [1:0]            state_q, state_d;
  logic                  data_got_q, data_got_d;
  logic [31:0]           data_buf_q, data_buf_d;

  logic                  is_load_s;
  logic                  dvalid_eff_s;
  logic                  mem2_flush_s;
  logic                  mem2_stall_s;
  logic                  rdy_in_s;
  logic                  out_valid_s;
  logic [31:0]           load_raw_s;
  logic [7:0]            load_byte_s;
  logic [15:0]           load_half_s;
  logic [31:0]           load_aligned_s;
  logic [31:0]           wr_data_s;

  // Stage control: load detection, stall/flush and handshake towards Memory1.
  always_comb begin
    is_load_s    = pass_in_q.is_mem & ~pass_in_q.is_store & ~excp_pass_in_q.valid;
    // A pulse seen while draining belongs to a flushed load and is ignored.
    dvalid_eff_s = dcache_data_valid & (state_q != ST_DRAIN);
    mem2_flush_s = flush | ~pass_in_q.valid;
    mem2_stall_s = ~next_rdy_in
                 | (is_load_s & ~data_got_q & ~dvalid_eff_s)
                 | (state_q == ST_DRAIN);
    rdy_in_s     = (mem2_flush_s & (state_q != ST_DRAIN)) | ~mem2_stall_s;
    out_valid_s  = ~mem2_flush_s & ~mem2_stall_s;
  end

  // Load data selection, byte/halfword alignment and sign/zero extension.
  always_comb begin
    load_raw_s = dvalid_eff_s ? dcache_rdata : data_buf_q;
    case (pass_in_q.byte_en)
      2'd0:    load_byte_s = load_raw_s[7:0];
      2'd1:    load_byte_s = load_raw_s[15:8];
      2'd2:    load_byte_s = load_raw_s[23:16];
      default: load_byte_s = load_raw_s[31:24];
    endcase
    if (pass_in_q.byte_en[1]) begin
      load_half_s = load_raw_s[31:16];
    end else begin
      load_half_s = load_raw_s[15:0];
    end
    case (pass_in_q.mem_size)
      MEM_BYTE: load_aligned_s = {{24{pass_in_q.is_signed & load_byte_s[7]}}, load_byte_s};
      MEM_HALF: load_aligned_s = {{16{pass_in_q.is_signed & load_half_s[15]}}, load_half_s};
      MEM_WORD: load_aligned_s = load_raw_s;
      default:  load_aligned_s = load_raw_s;
    endcase
  end

  // rd write data selection plus outputs towards writeback and forwarding.
  always_comb begin
    if (pass_in_q.is_wr_rd_pc_plus4) begin
      wr_data_s = pass_in_q.pc_plus4;
    end else if (is_load_s) begin
      wr_data_s = load_aligned_s;
    end else begin
      wr_data_s = pass_in_q.ex_out;
    end
    rdy_in             = rdy_in_s;
    pass_out.valid     = out_valid_s;
    pass_out.is_wr_rd  = pass_in_q.is_wr_rd;
    pass_out.rd        = pass_in_q.rd;
    pass_out.wr_data   = wr_data_s;
    excp_pass_out       = excp_pass_in_q;
    excp_pass_out.valid = excp_pass_in_q.valid & out_valid_s;
    fwd_req.valid      = pass_in_q.is_wr_rd & (pass_in_q.rd != 5'd0) & ~mem2_flush_s;
    fwd_req.idx        = pass_in_q.rd;
    fwd_req.data       = wr_data_s;
    fwd_req.data_valid = ~is_load_s | data_got_q | dvalid_eff_s;
  end

  // Next state for the load-response FSM and the early-response buffer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pass_in_q.valid & is_load_s & ~data_got_q & ~dcache_data_valid) begin
          // A load flushed before its response arrives must still drain it.
          state_d = flush ? ST_DRAIN : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dcache_data_valid) begin
          state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (dcache_data_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rdy_in_s | flush) begin
      data_got_d = 1'b0;
    end else if (dvalid_eff_s) begin
      data_got_d = 1'b1;
    end else begin
      data_got_d = data_got_q;
    end

    if (dvalid_eff_s) begin
      data_buf_d = dcache_rdata;
    end else begin
      data_buf_d = data_buf_q;
    end
  end

  // Input register; a flush while the stage cannot accept kills the held op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_in_q.valid <= 1'b0;
    end else if (rdy_in_s) begin
      pass_in_q      <= pass_in;
      excp_pass_in_q <= excp_pass_in;
    end else if (flush) begin
      pass_in_q.valid <= 1'b0;
    end
  end

  // FSM state and response buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_got_q <= 1'b0;
      data_buf_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      data_got_q <= data_got_d;
      data_buf_q <= data_buf_d;
    end
  end

endmodule

// File: doc/memory2.md
Name: memory2

Overview:
- Second memory pipeline stage; sits between the Memory1 stage and the writeback stage.
- Consumes the load response from the dcache. Aligns and sign- or zero-extends load data, and forwards the rd result.
- Passes the completed instruction and its exception state to writeback.
- Holds the stage while an issued load's data is outstanding. Stores at most one early response. Swallows the response of a load that was flushed.

Parameters:
- (none): widths fixed by cpu_defs (u32_t, 5-bit rd).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- dcache_data_valid  input  1  single-cycle pulse; load data present on dcache_rdata
- dcache_rdata  input  32  raw aligned-word read data from dcache
- fwd_req  output  forward_req_t  forwarding request to decode/execute
- flush  input  1  kill the instruction held in this stage
- next_rdy_in  input  1  writeback can accept
- rdy_in  output  1  this stage can accept pass_in this cycle
- pass_in  input  memory1_memory2_pass_t  from Memory1
- excp_pass_in  input  excp_pass_t  from Memory1
- pass_out  output  memory2_writeback_pass_t  to writeback
- excp_pass_out  output  excp_pass_t  to writeback

Behaviour:
- Input register: pass_in_r and excp_pass_in_r load on posedge clk when rdy_in=1. On reset only pass_in_r.valid is cleared to 0.
- is_load = pass_in_r.is_mem & ~pass_in_r.is_store & ~excp_pass_in_r.valid. Excepting instructions never wait, because Memory1 issued no dcache op for them.
- FSM states: IDLE, WAIT, DRAIN. Reset state is IDLE.
  - IDLE: a valid is_load with no captured data moves to WAIT, unless dcache_data_valid arrives in the same cycle.
  - WAIT → IDLE: on dcache_data_valid.
  - WAIT → DRAIN: on flush while the response is outstanding.
  - DRAIN: the next dcache_data_valid is discarded, then IDLE. rdy_in=0 while in DRAIN so no new load is mixed with the stale response.
  - A flush and dcache_data_valid in the same WAIT cycle go to IDLE; the data is discarded.
- Data buffer: on dcache_data_valid in IDLE/WAIT, dcache_rdata is latched into data_buf and data_got is set to 1.
  - data_got clears when the instruction leaves (rdy_in=1) or on flush. Reset: data_got=0, data_buf=0.
- Effective load data: dcache_rdata in the pulse cycle, else data_buf.
- mem2_flush = flush | ~pass_in_r.valid.
- mem2_stall = ~next_rdy_in | (is_load & ~data_got & ~dcache_data_valid) | (state==DRAIN).
- rdy_in = (mem2_flush & state!=DRAIN) | ~mem2_stall.
- pass_out.valid = ~mem2_flush & ~mem2_stall.
- Alignment uses pass_in_r.byte_en (va[1:0]):
  - BYTE: byte at offset byte_en*8.
  - HALF_WORD: halfword at byte_en[1]*16.
  - WORD: whole word.
  - Extension: sign-extend when is_signed, else zero-extend to 32 bits.
- Write data:
  - is_wr_rd_pc_plus4 → pc_plus4.
  - Else loads → aligned load data.
  - Else ex_out.
- Forwarding:
  - fwd_req.valid = is_wr_rd & rd!=0 & ~mem2_flush.
  - fwd_req.idx = rd; fwd_req.data = write data.
  - fwd_req.data_valid = ~is_load | data_got | dcache_data_valid.
- excp_pass_out:
  - Equals excp_pass_in_r when pass_out.valid.
  - Otherwise valid=0, with the remaining fields passed through.
- Combinational latency: pass_out is registered-input plus combinational logic, 1 cycle for non-loads. Loads take 1 + the dcache wait cycles.
- Unused byte_en bits for WORD are ignored. Misalignment is already trapped upstream.

Test Plan:
1. ld.b signed, byte_en=2'b11, dcache_rdata=32'h80FF_1234 with the pulse in the same cycle → write data 32'hFFFF_FF80, pass_out.valid=1 that cycle.
2. ld.hu, byte_en=2'b10, data arrives 3 cycles late as 32'hBEEF_0000 → rdy_in=0 and fwd_req.data_valid=0 for 3 cycles, then write data 32'h0000_BEEF.
3. ld.w, data pulse arrives while next_rdy_in=0 for 2 cycles → data_buf holds the value. pass_out.valid=1 with the correct data when next_rdy_in rises; no second pulse required.
4. flush during WAIT, response 2 cycles later → state DRAIN, rdy_in=0 until the pulse. The pulse is discarded, then rdy_in=1. A subsequent ld.w returns only its own data.
5. Instruction with excp_pass_in.valid=1 and is_mem=1 → no wait, excp_pass_out equals the input, pass_out.valid=1 next cycle.
6. Asynchronous rst_n low mid-WAIT → immediately: pass_out.valid=0, fwd_req.valid=0, state IDLE, data_got=0.
